mna_response_scheduler: RTL and testbench
=========================================

Name: mna_response_scheduler

Overview:
- Master-side NoC adapter (MNA) response-path scheduler.
- Shares one AXI4-Lite response port (B and R channels) between NUM_VC virtual-channel unit buffers that hold NoC response flits.
- Round-robin arbitrates packet heads, sequences each two-flit packet (header then payload), and drives a compliant B or R handshake.
- Sits between the VC input buffers and the AXI4-Lite slave-facing response channels.

Parameters:
- NUM_VC, 2, number of VC input buffers (2..8).
- DATA_W, 32, payload/rdata width; flit width FLIT_W = DATA_W+2.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- vc_valid  in  NUM_VC  head flit of VC i present.
- vc_flit  in  NUM_VC*FLIT_W  head flit of VC i at slice i. Fields: [DATA_W+1] head; [DATA_W] read (header only); [1:0] resp (header) or data (payload).
- vc_pop  out  NUM_VC  combinational one-hot; consumes the head flit of VC i this cycle.
- bresp  out  2  write response code.
- bvalid  out  1  write response valid.
- bready  in  1  write response accepted.
- rdata  out  DATA_W  read data.
- rresp  out  2  read response code.
- rvalid  out  1  read response valid.
- rready  in  1  read response accepted.
- err_orphan  out  1  sticky: a payload flit arrived with no header.
- err_clear  in  1  synchronous clear of err_orphan.

Behaviour:
- Reset (async, immediate): state=IDLE, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, err_orphan=0, last_grant=NUM_VC-1 (VC0 wins first). vc_pop is 0 while reset_n=0. A packet in flight is abandoned; its flits already popped are lost.
- IDLE:
  - Round-robin over vc_valid, searching from last_grant+1 with wrap.
  - Winner g gets vc_pop[g]=1 in the same cycle; grant<=g and last_grant<=g.
  - If the flit is a header: latch read and resp[1:0], go to PAYLOAD.
  - If the flit is not a header (orphan): discard it, set err_orphan, stay in IDLE.
  - No vc_valid: hold.
- PAYLOAD:
  - Only VC grant is considered; the other VCs wait.
  - vc_valid[grant] & !head: vc_pop[grant]=1.
    - If read=1: rdata<=payload, rresp<=latched resp, rvalid<=1, go to SEND_R.
    - If read=0: bresp<=payload[1:0], bvalid<=1, go to SEND_B.
  - vc_valid[grant] & head: no pop, set err_orphan (truncated packet), go to IDLE. The new header is re-arbitrated normally.
  - vc_valid[grant]=0: wait, no timeout.
- SEND_B: bvalid=1 and bresp stable until bready=1 is sampled. On handshake: bvalid<=0, go to IDLE. bvalid never depends combinationally on bready.
- SEND_R: same as SEND_B, using rvalid/rready, with rdata and rresp stable.
- Handshake rules:
  - bvalid and rvalid are never both 1.
  - A ready asserted before valid has no effect.
  - A ready held high gives a handshake in the first valid cycle.
- Latency and throughput:
  - Header pop to valid high: header cycle + payload cycle, so valid is seen 2 clocks after the header pop edge.
  - Minimum of 3 cycles per packet with ready held high.
- err_orphan: set has priority over a same-cycle err_clear.
- vc_pop is at most one-hot, and never asserted in SEND_B or SEND_R.

Decomposition:
- Package mna_resp_pkg:
  - state encoding IDLE / PAYLOAD / SEND_B / SEND_R;
  - flit field positions HEAD_BIT, READ_BIT, RESP_LSB/MSB;
  - AXI response constants OKAY=2'b00, SLVERR=2'b10.
- Sub-module mna_rr_arbiter (parameter N): inputs req[N], last_grant, enable; outputs one-hot gnt and grant index. Purely combinational pointer search; last_grant is held in the parent.

Test Plan:
- Write packet on VC0 (header read=0, payload 0x00000002), bready=1 -> vc_pop[0] pulses in 2 consecutive cycles; bvalid=1 with bresp=2'b10 for exactly 1 cycle; rvalid stays 0.
- Read packet on VC1 (header read=1 resp=0, payload 0xDEADBEEF), rready=0 for 5 cycles then 1 -> rvalid held 5+ cycles with rdata=0xDEADBEEF stable; deasserts the cycle after the handshake.
- Both VCs continuously hold packets after reset -> grants alternate VC0, VC1, VC0, VC1 over 4 packets; no VC starves.
- Payload flit at the head of VC0 in IDLE -> popped, err_orphan=1, no bvalid/rvalid; err_clear=1 for 1 cycle -> err_orphan=0.
- Header in PAYLOAD instead of payload -> no pop, err_orphan=1, return to IDLE; that header is then served as a new packet.
- reset_n low while in SEND_R -> rvalid=0 immediately, asynchronously; after release the next grant goes to VC0.

Source files
------------

// File: rtl/mna_resp_pkg.sv
// Shared types and constants for the MNA response-path scheduler.
// Flit layout: [DATA_W+1] head, [DATA_W] read (header only), low bits resp or payload data.
package mna_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    SEND_B,
    SEND_R
  } state_t;

  localparam int unsigned RESP_LSB = 0;
  localparam int unsigned RESP_MSB = 1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  function automatic int unsigned head_bit(input int unsigned data_w);
    return data_w + 1;
  endfunction

  function automatic int unsigned read_bit(input int unsigned data_w);
    return data_w;
  endfunction

endpackage

// File: rtl/mna_rr_arbiter.sv
// Combinational round-robin pointer search: first requester after last_grant, with wrap.
// The pointer register itself lives in the parent.
module mna_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  input  logic             enable,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] grant
);

  logic found;

  always_comb begin
    gnt   = '0;
    grant = '0;
    found = 1'b0;
    for (int unsigned ofs = 1; ofs <= N; ofs++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (enable && !found && req[j] &&
            (j == (32'(last_grant) + ofs) % N)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          grant  = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/mna_response_scheduler.sv
// Shares one AXI4-Lite B/R response port between NUM_VC NoC response buffers,
// sequencing two-flit packets (header, payload) under round-robin arbitration.
module mna_response_scheduler
  import mna_resp_pkg::*;
#(
  parameter int unsigned NUM_VC = 2,
  parameter int unsigned DATA_W = 32
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_VC-1:0]              vc_valid,
  input  logic [NUM_VC*(DATA_W+2)-1:0]   vc_flit,
  output logic [NUM_VC-1:0]              vc_pop,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  output logic [DATA_W-1:0]              rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic                           err_orphan,
  input  logic                           err_clear
);

  localparam int unsigned FLIT_W   = DATA_W + 2;
  localparam int unsigned IDX_W    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int unsigned HEAD_BIT = head_bit(DATA_W);
  localparam int unsigned READ_BIT = read_bit(DATA_W);

  state_t             state, state_next;
  logic [IDX_W-1:0]   grant, last_grant, arb_idx, sel_idx;
  logic [NUM_VC-1:0]  arb_gnt, grant_oh, pop_c;
  logic [FLIT_W-1:0]  cur_flit;
  logic               cur_valid, cur_head;
  logic               read_q;
  logic [1:0]         resp_q;
  logic               set_orphan, load_hdr, load_b, load_r, take_grant;

  mna_rr_arbiter #(
    .N     (NUM_VC),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (vc_valid),
    .last_grant (last_grant),
    .enable     (state == IDLE),
    .gnt        (arb_gnt),
    .grant      (arb_idx)
  );

  // In IDLE the arbiter winner is inspected; otherwise only the latched grant.
  assign sel_idx = (state == IDLE) ? arb_idx : grant;

  always_comb begin
    cur_flit  = '0;
    cur_valid = 1'b0;
    grant_oh  = '0;
    for (int unsigned i = 0; i < NUM_VC; i++) begin
      if (IDX_W'(i) == sel_idx) begin
        cur_flit  = vc_flit[i*FLIT_W +: FLIT_W];
        cur_valid = vc_valid[i];
      end
      if (IDX_W'(i) == grant) begin
        grant_oh[i] = 1'b1;
      end
    end
  end

  assign cur_head = cur_flit[HEAD_BIT];

  always_comb begin
    state_next = state;
    pop_c      = '0;
    set_orphan = 1'b0;
    load_hdr   = 1'b0;
    load_b     = 1'b0;
    load_r     = 1'b0;
    take_grant = 1'b0;
    case (state)
      IDLE: begin
        if (arb_gnt != '0) begin
          pop_c      = arb_gnt;
          take_grant = 1'b1;
          if (cur_head) begin
            load_hdr   = 1'b1;
            state_next = PAYLOAD;
          end else begin
            set_orphan = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (cur_valid) begin
          if (!cur_head) begin
            pop_c = grant_oh;
            if (read_q) begin
              load_r     = 1'b1;
              state_next = SEND_R;
            end else begin
              load_b     = 1'b1;
              state_next = SEND_B;
            end
          end else begin
            // Truncated packet: leave the new header queued for re-arbitration.
            set_orphan = 1'b1;
            state_next = IDLE;
          end
        end
      end
      SEND_B: begin
        if (bready) begin
          state_next = IDLE;
        end
      end
      SEND_R: begin
        if (rready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset must silence the pop strobe immediately, not at the next edge.
  assign vc_pop = reset_n ? pop_c : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_VC - 1);
      read_q     <= 1'b0;
      resp_q     <= OKAY;
      bvalid     <= 1'b0;
      bresp      <= OKAY;
      rvalid     <= 1'b0;
      rresp      <= OKAY;
      rdata      <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_next;
      if (take_grant) begin
        grant      <= arb_idx;
        last_grant <= arb_idx;
      end
      if (load_hdr) begin
        read_q <= cur_flit[READ_BIT];
        resp_q <= cur_flit[RESP_MSB:RESP_LSB];
      end
      if (load_b) begin
        bresp  <= cur_flit[RESP_MSB:RESP_LSB];
        bvalid <= 1'b1;
      end else if (state == SEND_B && bready) begin
        bvalid <= 1'b0;
      end
      if (load_r) begin
        rdata  <= cur_flit[DATA_W-1:0];
        rresp  <= resp_q;
        rvalid <= 1'b1;
      end else if (state == SEND_R && rready) begin
        rvalid <= 1'b0;
      end
      if (set_orphan) begin
        err_orphan <= 1'b1;
      end else if (err_clear) begin
        err_orphan <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mna_response_scheduler.sv
// Scoreboard bench: stimulus pushes expected pops/responses, a negedge monitor checks them.
module tb_mna_response_scheduler;
  import mna_resp_pkg::*;

  localparam int unsigned NUM_VC = 2;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FLIT_W = DATA_W + 2;

  logic                      clock = 1'b0;
  logic                      reset_n;
  logic [NUM_VC-1:0]         vc_valid;
  logic [NUM_VC*FLIT_W-1:0]  vc_flit;
  logic [NUM_VC-1:0]         vc_pop;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [DATA_W-1:0]         rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;
  logic                      err_orphan;
  logic                      err_clear;

  mna_response_scheduler #(
    .NUM_VC (NUM_VC),
    .DATA_W (DATA_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .vc_valid   (vc_valid),
    .vc_flit    (vc_flit),
    .vc_pop     (vc_pop),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rvalid     (rvalid),
    .rready     (rready),
    .err_orphan (err_orphan),
    .err_clear  (err_clear)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_r;
    logic [1:0]  resp;
    logic [31:0] data;
    int unsigned wait_cyc;
  } exp_t;

  exp_t              exp_q[$];
  int unsigned       exp_pop[$];
  logic [FLIT_W-1:0] vq[NUM_VC][$];
  logic [NUM_VC-1:0] pend;
  int                checks   = 0;
  int                failures = 0;

  int unsigned mon_bwait = 0, mon_rwait = 0, mon_idx = 0;
  logic        mon_bhold = 1'b0, mon_rhold = 1'b0;
  logic [1:0]  mon_bresp = '0, mon_rresp = '0;
  logic [31:0] mon_rdata = '0;
  exp_t        mon_e;
  int unsigned n_ticks;

  function automatic logic [FLIT_W-1:0] hdr(input logic rd, input logic [1:0] rsp);
    return {1'b1, rd, 30'd0, rsp};
  endfunction

  function automatic logic [FLIT_W-1:0] pay(input logic [31:0] d);
    return {2'b00, d};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_VC; i++) begin
      vc_valid[i] = (vq[i].size() != 0);
      vc_flit[i*FLIT_W +: FLIT_W] = (vq[i].size() != 0) ? vq[i][0] : '0;
    end
  endtask

  task automatic push(input int vc, input logic [FLIT_W-1:0] f);
    vq[vc].push_back(f);
    refresh();
  endtask

  task automatic expect_b(input logic [1:0] rsp, input int unsigned w);
    exp_t e;
    e.is_r = 1'b0; e.resp = rsp; e.data = '0; e.wait_cyc = w;
    exp_q.push_back(e);
  endtask

  task automatic expect_r(input logic [1:0] rsp, input logic [31:0] d, input int unsigned w);
    exp_t e;
    e.is_r = 1'b1; e.resp = rsp; e.data = d; e.wait_cyc = w;
    exp_q.push_back(e);
  endtask

  // Pops are applied #1 after the edge so the DUT samples the pre-edge flit.
  task automatic tick();
    @(negedge clock);
    pend = vc_pop;
    @(posedge clock);
    #1;
    for (int i = 0; i < NUM_VC; i++) begin
      if (pend[i] && vq[i].size() != 0) void'(vq[i].pop_front());
    end
    refresh();
  endtask

  task automatic drain(input string name, input int unsigned limit, output int unsigned n);
    n = 0;
    while ((exp_q.size() != 0 || exp_pop.size() != 0) && n < limit) begin
      tick();
      n++;
    end
    chk(name, 64'((exp_q.size() == 0) && (exp_pop.size() == 0)), 64'd1);
  endtask

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        mon_bwait = 0; mon_rwait = 0; mon_bhold = 1'b0; mon_rhold = 1'b0;
      end else begin
        if (bvalid || rvalid) chk("valid_exclusive", 64'(bvalid && rvalid), 64'd0);
        if (vc_pop != '0) begin
          chk("pop_onehot", 64'($onehot(vc_pop)), 64'd1);
          for (int i = 0; i < NUM_VC; i++) if (vc_pop[i]) mon_idx = i;
          if (exp_pop.size() == 0) begin
            checks++; failures++;
            $display("FAIL pop_unexpected actual=vc%0d required=no_pop", mon_idx);
          end else begin
            chk("pop_order", 64'(mon_idx), 64'(exp_pop.pop_front()));
          end
        end
        if (mon_bhold) begin
          chk("bvalid_hold", 64'(bvalid), 64'd1);
          chk("bresp_stable", 64'(bresp), 64'(mon_bresp));
        end
        if (mon_rhold) begin
          chk("rvalid_hold", 64'(rvalid), 64'd1);
          chk("rdata_stable", 64'(rdata), 64'(mon_rdata));
          chk("rresp_stable", 64'(rresp), 64'(mon_rresp));
        end
        if (bvalid) begin
          if (bready) begin
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL b_unexpected actual=bresp_%0b required=no_response", bresp);
            end else begin
              mon_e = exp_q.pop_front();
              chk("b_kind", 64'(mon_e.is_r), 64'd0);
              chk("bresp", 64'(bresp), 64'(mon_e.resp));
              chk("b_wait", 64'(mon_bwait), 64'(mon_e.wait_cyc));
            end
            mon_bwait = 0;
          end else begin
            mon_bwait++;
          end
        end
        if (rvalid) begin
          if (rready) begin
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL r_unexpected actual=rdata_%0h required=no_response", rdata);
            end else begin
              mon_e = exp_q.pop_front();
              chk("r_kind", 64'(mon_e.is_r), 64'd1);
              chk("rresp", 64'(rresp), 64'(mon_e.resp));
              chk("rdata", 64'(rdata), 64'(mon_e.data));
              chk("r_wait", 64'(mon_rwait), 64'(mon_e.wait_cyc));
            end
            mon_rwait = 0;
          end else begin
            mon_rwait++;
          end
        end
        mon_bhold = bvalid && !bready;
        mon_rhold = rvalid && !rready;
        mon_bresp = bresp;
        mon_rresp = rresp;
        mon_rdata = rdata;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; bready = 1'b0; rready = 1'b0; err_clear = 1'b0;
    vc_valid = '0; vc_flit = '0;
    repeat (2) tick();
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_err", 64'(err_orphan), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_resp", 64'({bresp, rresp}), 64'd0);

    // Write packet on VC0, bready held high
    push(0, hdr(1'b0, OKAY)); push(0, pay(32'h0000_0002));
    exp_pop.push_back(0); exp_pop.push_back(0);
    expect_b(SLVERR, 0);
    bready = 1'b1;
    #1 chk("pop_in_reset", 64'(vc_pop), 64'd0);
    tick();
    reset_n = 1'b1;
    tick(); tick();
    chk("t1_bvalid_latency", 64'(bvalid), 64'd1);
    chk("t1_bresp", 64'(bresp), 64'(SLVERR));
    chk("t1_rvalid_low", 64'(rvalid), 64'd0);
    tick();
    chk("t1_bvalid_one_cycle", 64'(bvalid), 64'd0);
    drain("t1_drain", 5, n_ticks);

    // Read packet on VC1, rready low for 5 valid cycles
    rready = 1'b0;
    push(1, hdr(1'b1, OKAY)); push(1, pay(32'hDEAD_BEEF));
    exp_pop.push_back(1); exp_pop.push_back(1);
    expect_r(OKAY, 32'hDEAD_BEEF, 5);
    tick(); tick();
    chk("t2_rvalid", 64'(rvalid), 64'd1);
    chk("t2_rdata", 64'(rdata), 64'hDEAD_BEEF);
    repeat (5) tick();
    chk("t2_rvalid_held", 64'(rvalid), 64'd1);
    rready = 1'b1;
    tick();
    chk("t2_rvalid_drop", 64'(rvalid), 64'd0);
    drain("t2_drain", 5, n_ticks);

    // Both VCs loaded: grants alternate, 3 cycles per packet
    push(0, hdr(1'b0, OKAY)); push(0, pay(32'h1));
    push(0, hdr(1'b1, OKAY)); push(0, pay(32'hA0A0_A0A0));
    push(1, hdr(1'b0, OKAY)); push(1, pay(32'h3));
    push(1, hdr(1'b1, SLVERR)); push(1, pay(32'hB1B1_B1B1));
    exp_pop.push_back(0); exp_pop.push_back(0); exp_pop.push_back(1); exp_pop.push_back(1);
    exp_pop.push_back(0); exp_pop.push_back(0); exp_pop.push_back(1); exp_pop.push_back(1);
    expect_b(2'b01, 0);
    expect_b(2'b11, 0);
    expect_r(OKAY, 32'hA0A0_A0A0, 0);
    expect_r(SLVERR, 32'hB1B1_B1B1, 0);
    drain("t3_drain", 40, n_ticks);
    chk("t3_throughput", 64'(n_ticks), 64'd12);

    // Orphan payload in IDLE, then set-over-clear priority
    push(0, pay(32'h5));
    exp_pop.push_back(0);
    tick();
    chk("t4_err_set", 64'(err_orphan), 64'd1);
    chk("t4_no_valid", 64'({bvalid, rvalid}), 64'd0);
    err_clear = 1'b1;
    tick();
    chk("t4_err_clear", 64'(err_orphan), 64'd0);
    push(0, pay(32'h6));
    exp_pop.push_back(0);
    tick();
    chk("t4_set_beats_clear", 64'(err_orphan), 64'd1);
    err_clear = 1'b0;
    tick();
    chk("t4_err_sticky", 64'(err_orphan), 64'd1);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t4_err_clear2", 64'(err_orphan), 64'd0);

    // Header where payload expected: truncated packet, new header served
    push(1, hdr(1'b0, OKAY)); push(1, hdr(1'b1, SLVERR)); push(1, pay(32'h77));
    exp_pop.push_back(1); exp_pop.push_back(1); exp_pop.push_back(1);
    expect_r(SLVERR, 32'h77, 0);
    tick(); tick();
    chk("t5_err_trunc", 64'(err_orphan), 64'd1);
    drain("t5_drain", 10, n_ticks);
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    chk("t5_err_clear", 64'(err_orphan), 64'd0);

    // Async reset in SEND_R, then VC0 wins first
    rready = 1'b0;
    push(0, hdr(1'b1, OKAY)); push(0, pay(32'h1234));
    exp_pop.push_back(0); exp_pop.push_back(0);
    tick(); tick();
    chk("t6_rvalid", 64'(rvalid), 64'd1);
    chk("t6_rdata", 64'(rdata), 64'h1234);
    #1 reset_n = 1'b0;
    #1 chk("t6_rvalid_async", 64'(rvalid), 64'd0);
    push(0, hdr(1'b0, OKAY)); push(0, pay(32'h0));
    push(1, hdr(1'b0, OKAY)); push(1, pay(32'h2));
    #1 chk("t6_pop_in_reset", 64'(vc_pop), 64'd0);
    exp_pop.push_back(0); exp_pop.push_back(0); exp_pop.push_back(1); exp_pop.push_back(1);
    expect_b(OKAY, 0);
    expect_b(SLVERR, 0);
    bready = 1'b1; rready = 1'b1;
    tick();
    reset_n = 1'b1;
    drain("t6_drain", 20, n_ticks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
